// File: rtl/ping_pong_ctrl_if.sv
// Stream and buffer-port bundle for ping_pong_ctrl.
// master = the controller, slave = the producer/consumer/buffer side.
interface ping_pong_ctrl_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int WE_WIDTH   = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic                  out_last;
  logic                  u0_wr;
  logic                  u1_wr;
  logic                  u0_rd;
  logic                  u1_rd;
  logic                  ena;
  logic [WE_WIDTH-1:0]   wea;
  logic [ADDR_WIDTH-1:0] addra;
  logic [WIDTH-1:0]      dina;
  logic                  enb;
  logic [ADDR_WIDTH-1:0] addrb;
  logic [WIDTH-1:0]      doutb;

  modport master (
    input  in_valid, in_data, out_ready, doutb,
    output in_ready, out_valid, out_data, out_last,
    output u0_wr, u1_wr, u0_rd, u1_rd,
    output ena, wea, addra, dina, enb, addrb
  );

  modport slave (
    output in_valid, in_data, out_ready, doutb,
    input  in_ready, out_valid, out_data, out_last,
    input  u0_wr, u1_wr, u0_rd, u1_rd,
    input  ena, wea, addra, dina, enb, addrb
  );
endinterface

// File: rtl/ping_pong_ctrl.sv
// Ping-pong buffer controller: fills one bank from the input stream while draining the other.
// Optional status outputs (bank_full, frame_cnt) are enabled by defining PP_STATUS_EN.
module ping_pong_ctrl #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int WE_WIDTH   = 4,
  parameter int DEPTH      = 256
) (
  input  logic             clk,
  input  logic             rst,
  ping_pong_ctrl_if.master bus
`ifdef PP_STATUS_EN
  ,
  output logic [1:0]       bank_full,
  output logic [15:0]      frame_cnt
`endif
);

  typedef enum logic {IDLE, READ} rd_state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   LAST_CNT  = (ADDR_WIDTH + 1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [1:0]            full_reg, full_next;
  logic                  wr_bank_reg;
  logic [ADDR_WIDTH-1:0] wr_addr_reg;
  rd_state_t             state_reg, state_next;
  logic                  rd_bank_reg, rd_bank_next;
  logic [ADDR_WIDTH:0]   rd_cnt_reg, rd_cnt_next;
  logic                  inflight_reg, inflight_last_reg;

  logic [WIDTH-1:0]      fifo_data_reg [2];
  logic [1:0]            fifo_last_reg;
  logic                  fifo_head_reg, fifo_tail_reg;
  logic [1:0]            fifo_count_reg;

  logic                  wr_xfer, wr_wrap, pop, cap_last, issue;
  logic [2:0]            slots_used;
  logic [1:0]            u_wr, u_rd;

  // Write side
  assign bus.in_ready = ~full_reg[wr_bank_reg];
  assign wr_xfer      = bus.in_valid & bus.in_ready;
  assign wr_wrap      = wr_xfer & (wr_addr_reg == LAST_ADDR);
  assign bus.ena      = wr_xfer;
  assign bus.wea      = {WE_WIDTH{1'b1}};
  assign bus.addra    = wr_addr_reg;
  assign bus.dina     = bus.in_data;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sel
      assign u_wr[gi] = (wr_bank_reg == 1'(gi)) & ~full_reg[gi];
      assign u_rd[gi] = (state_reg == READ) & (rd_bank_reg == 1'(gi));
    end
  endgenerate

  assign bus.u0_wr = u_wr[0];
  assign bus.u1_wr = u_wr[1];
  assign bus.u0_rd = u_rd[0];
  assign bus.u1_rd = u_rd[1];

  // Output FIFO view
  assign bus.out_valid = (fifo_count_reg != 2'd0);
  assign bus.out_data  = fifo_data_reg[fifo_head_reg];
  assign bus.out_last  = bus.out_valid & fifo_last_reg[fifo_head_reg];
  assign pop           = bus.out_valid & bus.out_ready;
  assign cap_last      = inflight_reg & inflight_last_reg;

  // Counting the slot freed by this cycle's pop is what keeps back-to-back issue at 1 word/cycle.
  assign slots_used = {1'b0, fifo_count_reg} + {2'b00, inflight_reg} - {2'b00, pop};
  assign issue      = (state_reg == READ) && (rd_cnt_reg != DEPTH_CNT) && (slots_used < 3'd2);

  assign bus.enb   = issue;
  assign bus.addrb = rd_cnt_reg[ADDR_WIDTH-1:0];

  always_comb begin
    state_next   = state_reg;
    rd_bank_next = rd_bank_reg;
    rd_cnt_next  = rd_cnt_reg;
    full_next    = full_reg;
    if (issue) begin
      rd_cnt_next = rd_cnt_reg + 1'b1;
    end
    case (state_reg)
      IDLE: begin
        if (full_reg[rd_bank_reg]) begin
          state_next = READ;
        end
      end
      READ: begin
        if (cap_last) begin
          full_next[rd_bank_reg] = 1'b0;
          rd_bank_next           = ~rd_bank_reg;
          rd_cnt_next            = '0;
          state_next             = full_reg[~rd_bank_reg] ? READ : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // Never the bank being cleared: a set needs ~full, a clear needs full.
    if (wr_wrap) begin
      full_next[wr_bank_reg] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_reg          <= '0;
      wr_bank_reg       <= 1'b0;
      wr_addr_reg       <= '0;
      state_reg         <= IDLE;
      rd_bank_reg       <= 1'b0;
      rd_cnt_reg        <= '0;
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
      fifo_last_reg     <= '0;
      fifo_head_reg     <= 1'b0;
      fifo_tail_reg     <= 1'b0;
      fifo_count_reg    <= '0;
    end else begin
      full_reg          <= full_next;
      state_reg         <= state_next;
      rd_bank_reg       <= rd_bank_next;
      rd_cnt_reg        <= rd_cnt_next;
      inflight_reg      <= issue;
      inflight_last_reg <= issue & (rd_cnt_reg == LAST_CNT);
      if (wr_xfer) begin
        wr_addr_reg <= wr_wrap ? '0 : wr_addr_reg + 1'b1;
        wr_bank_reg <= wr_bank_reg ^ wr_wrap;
      end
      if (inflight_reg) begin
        fifo_last_reg[fifo_tail_reg] <= inflight_last_reg;
        fifo_tail_reg                <= ~fifo_tail_reg;
      end
      if (pop) begin
        fifo_head_reg <= ~fifo_head_reg;
      end
      fifo_count_reg <= fifo_count_reg + 2'(inflight_reg) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (inflight_reg) begin
      fifo_data_reg[fifo_tail_reg] <= bus.doutb;
    end
  end

`ifdef PP_STATUS_EN
  logic [15:0] frame_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_reg <= '0;
    end else if (pop && bus.out_last) begin
      frame_cnt_reg <= frame_cnt_reg + 1'b1;
    end
  end

  assign bank_full = full_reg;
  assign frame_cnt = frame_cnt_reg;
`endif

  // A bank is never selected for write and read at once, and only one bank is read.
  assert property (@(posedge clk) disable iff (rst)
    !(u_wr[0] && u_rd[0]) && !(u_wr[1] && u_rd[1]) && !(u_rd[0] && u_rd[1]));

endmodule

// File: tb/tb_ping_pong_ctrl.sv
// Self-checking bench for ping_pong_ctrl: cycle-exact vector table, directed corner sequences,
// and random traffic checked against a frame-level queue model with an external two-bank buffer.
module tb_ping_pong_ctrl;
  localparam int W   = 32;
  localparam int AW  = 4;
  localparam int WEW = 4;
  localparam int D   = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ping_pong_ctrl_if #(.WIDTH(W), .ADDR_WIDTH(AW), .WE_WIDTH(WEW)) bus ();

`ifdef PP_STATUS_EN
  logic [1:0]  bank_full;
  logic [15:0] frame_cnt;
`endif

  ping_pong_ctrl #(.WIDTH(W), .ADDR_WIDTH(AW), .WE_WIDTH(WEW), .DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef PP_STATUS_EN
    ,
    .bank_full (bank_full),
    .frame_cnt (frame_cnt)
`endif
  );

  // External two-bank buffer: synchronous write, read data one cycle after enb.
  logic [W-1:0] mem0 [0:(1<<AW)-1];
  logic [W-1:0] mem1 [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.ena) begin
      if (bus.u0_wr) mem0[bus.addra] <= bus.dina;
      else if (bus.u1_wr) mem1[bus.addra] <= bus.dina;
    end
    if (bus.enb) bus.doutb <= bus.u1_rd ? mem1[bus.addrb] : mem0[bus.addrb];
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level reference model
  logic [W-1:0] pend_q[$];
  logic [W-1:0] exp_q[$];
  int acc_total, last_pops, out_idx, issued, popped;
  bit hold_prev;
  logic [W-1:0] prev_data;
  logic prev_last;

  task automatic model_clear();
    pend_q.delete();
    exp_q.delete();
    acc_total = 0; last_pops = 0; out_idx = 0; issued = 0; popped = 0;
    hold_prev = 1'b0;
  endtask

  task automatic monitor();
    bit acc, pop;
    acc = bus.in_valid && bus.in_ready;
    pop = bus.out_valid && bus.out_ready;
    chk("ena", bus.ena, acc);
    if (acc) begin
      chk("wea", bus.wea, {WEW{1'b1}});
      chk("addra_range", bus.addra < D, 1);
      chk("dina", bus.dina, bus.in_data);
      chk("wr_sel_one", bus.u0_wr ^ bus.u1_wr, 1);
    end
    if (acc_total - D * last_pops < 2 * D) chk("in_ready_free", bus.in_ready, 1);
    if (bus.enb) begin
      chk("addrb_range", bus.addrb < D, 1);
      chk("rd_sel_one", bus.u0_rd ^ bus.u1_rd, 1);
    end
    chk("excl", {bus.u0_wr & bus.u0_rd, bus.u1_wr & bus.u1_rd, bus.u0_rd & bus.u1_rd}, 0);
    if (!bus.out_valid) chk("last_idle", bus.out_last, 0);
    if (hold_prev) begin
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_data", bus.out_data, prev_data);
      chk("hold_last", bus.out_last, prev_last);
    end
`ifdef PP_STATUS_EN
    chk("frame_cnt", frame_cnt, 64'(last_pops & 16'hFFFF));
`endif
    if (pop) begin
      chk("out_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        chk("out_data", bus.out_data, exp_q.pop_front());
        chk("out_last", bus.out_last, (out_idx % D) == D - 1);
        if ((out_idx % D) == D - 1) last_pops++;
        out_idx++;
      end
    end
    if (bus.enb) issued++;
    if (pop) popped++;
    chk("outstanding", (issued - popped) <= 2, 1);
    if (acc) begin
      pend_q.push_back(bus.in_data);
      acc_total++;
      if (pend_q.size() == D) begin
        foreach (pend_q[i]) exp_q.push_back(pend_q[i]);
        pend_q.delete();
      end
    end
    hold_prev = bus.out_valid && !bus.out_ready;
    prev_data = bus.out_data;
    prev_last = bus.out_last;
  endtask

  task automatic tick();
    #2;
    monitor();
    @(posedge clk);
    #1;
  endtask

  // mode: 0 out_ready=1, 1 out_ready=0, 2 out_ready toggles
  task automatic send_words(input int start, input int n, input int mode, input bit need_ready);
    int i = 0;
    int cyc = 0;
    bit took;
    while (i < n && cyc < 200) begin
      bus.in_valid  = 1'b1;
      bus.in_data   = W'(start + i);
      bus.out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : cyc[0];
      #1;
      if (need_ready) chk("in_ready_cont", bus.in_ready, 1);
      took = bus.in_ready;
      tick();
      if (took) i++;
      cyc++;
    end
    bus.in_valid = 1'b0;
    chk("send_done", i, n);
  endtask

  task automatic drain();
    int cyc = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while ((exp_q.size() != 0 || bus.out_valid) && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_idle", bus.out_valid, 0);
  endtask

  typedef struct {
    logic iv; logic [W-1:0] id; logic ordy;
    logic e_ir, e_ena, e_ov; logic [W-1:0] e_od; logic e_ol;
    logic e_u0w, e_u1w, e_u0r, e_u1r, e_enb; logic [1:0] e_full;
  } vec_t;

  vec_t tbl [12];

  initial begin
    tbl[0]  = '{1'b1, 32'h10, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
    tbl[1]  = '{1'b1, 32'h11, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
    tbl[2]  = '{1'b1, 32'h12, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
    tbl[3]  = '{1'b1, 32'h13, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
    tbl[4]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01};
    tbl[5]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01};
    tbl[6]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01};
    tbl[7]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01};
    tbl[8]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b1, 32'h11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01};
    tbl[9]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b1, 32'h12, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01};
    tbl[10] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b1, 32'h13, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
    tbl[11] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00};

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();

    // Cycle-exact single frame, starting from the reset state
    for (int r = 0; r < 12; r++) begin
      bus.in_valid  = tbl[r].iv;
      bus.in_data   = tbl[r].id;
      bus.out_ready = tbl[r].ordy;
      #1;
      chk($sformatf("t%0d_in_ready", r), bus.in_ready, tbl[r].e_ir);
      chk($sformatf("t%0d_ena", r), bus.ena, tbl[r].e_ena);
      chk($sformatf("t%0d_out_valid", r), bus.out_valid, tbl[r].e_ov);
      if (tbl[r].e_ov) chk($sformatf("t%0d_out_data", r), bus.out_data, tbl[r].e_od);
      chk($sformatf("t%0d_out_last", r), bus.out_last, tbl[r].e_ol);
      chk($sformatf("t%0d_sel", r), {bus.u0_wr, bus.u1_wr, bus.u0_rd, bus.u1_rd},
          {tbl[r].e_u0w, tbl[r].e_u1w, tbl[r].e_u0r, tbl[r].e_u1r});
      chk($sformatf("t%0d_enb", r), bus.enb, tbl[r].e_enb);
`ifdef PP_STATUS_EN
      chk($sformatf("t%0d_bank_full", r), bank_full, tbl[r].e_full);
`endif
      tick();
    end

    // Eight words back to back: banks alternate, in_ready never drops
    send_words(0, 8, 0, 1'b1);
    drain();

    // Consumer stalled: both banks fill, head word held, then release
    send_words(0, 8, 1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'b1; bus.in_data = W'(8); bus.out_ready = 1'b0;
      #1;
      chk("stall_in_ready", bus.in_ready, 0);
      chk("stall_out_valid", bus.out_valid, 1);
      chk("stall_out_data", bus.out_data, 0);
      tick();
    end
    send_words(8, 4, 0, 1'b0);
    drain();

    // out_ready toggling during the drain
    send_words(32'h100, 8, 2, 1'b0);
    drain();

    // Reset midway through filling bank 1
    bus.out_ready = 1'b1;
    send_words(32'h200, 6, 0, 1'b0);
    rst = 1'b1; bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_sel", {bus.u0_wr, bus.u1_wr, bus.u0_rd, bus.u1_rd}, 4'b1000);
    chk("rst_enb", bus.enb, 0);
`ifdef PP_STATUS_EN
    chk("rst_bank_full", bank_full, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
`endif
    tick();
    send_words(32'h300, 4, 0, 1'b1);
    drain();

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.in_data   = $urandom;
      bus.out_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
